// File: rtl/seg7_disp_sched_if.sv
// Purpose: groups the data/control signals between the display sources and
//          the seg7_disp_sched scheduler.
// Signals:
//   srcVal         four 32-bit source values, src n = srcVal[32n+31:32n]
//   srcValid       bit n set: source n takes part in rotation
//   selForce       [2] force enable, [1:0] forced source index
//   alertReq       one-cycle pulse requesting an alert message
//   alertVal       alert value, captured on alertReq
//   outDispVal     value for the segment driver
//   outStrobe1kHz  one-cycle 1 kHz strobe
//   outStrobeNoise pseudo-random noise bit
//   outCurSrc      0..3 source shown, 4 alert, 7 idle
//   outAlertBusy   high while an alert is on screen
// Modports: master = source side (drives requests), slave = scheduler side.
interface seg7_disp_sched_if;
  logic [127:0] srcVal;
  logic [3:0]   srcValid;
  logic [2:0]   selForce;
  logic         alertReq;
  logic [31:0]  alertVal;
  logic [31:0]  outDispVal;
  logic         outStrobe1kHz;
  logic         outStrobeNoise;
  logic [2:0]   outCurSrc;
  logic         outAlertBusy;

  modport master (
    output srcVal, srcValid, selForce, alertReq, alertVal,
    input  outDispVal, outStrobe1kHz, outStrobeNoise, outCurSrc, outAlertBusy
  );

  modport slave (
    input  srcVal, srcValid, selForce, alertReq, alertVal,
    output outDispVal, outStrobe1kHz, outStrobeNoise, outCurSrc, outAlertBusy
  );
endinterface

// File: rtl/seg7_disp_sched.sv
// Purpose: scheduler in front of the 8-digit 7-segment hex driver. Builds the
//          1 kHz and noise strobes and time-shares the 32-bit display value
//          between four rotating sources, a forced source and a one-shot
//          alert (priority ALERT > FORCE > ROTATE > IDLE).
// Ports:
//   clock   system clock, all state on posedge
//   reset   synchronous, active-high
//   io_bus  seg7_disp_sched_if.slave (source inputs, driver outputs)
module seg7_disp_sched #(
  parameter int CLK_KHZ  = 50000,
  parameter int DWELL_MS = 2000,
  parameter int ALERT_MS = 1000
) (
  input  logic               clock,
  input  logic               reset,
  seg7_disp_sched_if.slave   io_bus
);

  localparam int PW    = (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;
  localparam int MAXMS = (DWELL_MS > ALERT_MS) ? DWELL_MS : ALERT_MS;
  localparam int MW    = (MAXMS > 1) ? $clog2(MAXMS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_KHZ - 1);
  localparam logic [MW-1:0] DWELL_LAST = MW'(DWELL_MS - 1);
  localparam logic [MW-1:0] ALERT_LAST = MW'(ALERT_MS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_FORCE  = 2'd2,
    ST_ALERT  = 2'd3
  } state_t;

  // First set bit of valid searching start, start+1, start+2, start+3 (mod 4).
  function automatic logic [1:0] f_pick(input logic [3:0] valid, input logic [1:0] start);
    logic [1:0] res;
    logic [1:0] idx;
    res = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (valid[idx]) res = idx;
    end
    return res;
  endfunction

  state_t        r_state;
  logic [1:0]    r_cur;
  logic [MW-1:0] r_ms;
  logic [PW-1:0] r_presc;
  logic          r_strobe;
  logic [15:0]   r_lfsr;
  logic          r_noise;
  logic [31:0]   r_alert_val;
  logic [31:0]   r_disp;
  logic [2:0]    r_cur_out;
  logic          r_busy;

  state_t        w_state_nx;
  logic [1:0]    w_cur_nx;
  logic [MW-1:0] w_ms_nx;
  logic [31:0]   w_alert_nx;
  logic [31:0]   w_sel_val;
  logic [1:0]    w_pick_inc;
  logic [1:0]    w_pick_adv;
  logic          w_dwell_exp;
  logic          w_alert_exp;
  logic          w_lfsr_fb;

  // Taps 16,14,13,11 in right-shifting Fibonacci form.
  assign w_lfsr_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_dwell_exp = r_strobe && (r_ms == DWELL_LAST);
  assign w_alert_exp = r_strobe && (r_ms == ALERT_LAST);
  // inc: resume search that may land on r_cur; adv: rotation step that tries others first.
  assign w_pick_inc  = f_pick(io_bus.srcValid, r_cur);
  assign w_pick_adv  = f_pick(io_bus.srcValid, r_cur + 2'd1);
  assign w_sel_val   = io_bus.srcVal[{w_cur_nx, 5'd0} +: 32];

  // Prescaler and noise generator.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc  <= '0;
      r_strobe <= 1'b0;
      r_lfsr   <= 16'hACE1;
      r_noise  <= 1'b0;
    end else begin
      r_presc  <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
      r_strobe <= (r_presc == PRESC_LAST);
      r_lfsr   <= {w_lfsr_fb, r_lfsr[15:1]};
      r_noise  <= r_lfsr[0];
    end
  end

  // Next-state, source selection and millisecond timer.
  always_comb begin
    w_state_nx = r_state;
    w_cur_nx   = r_cur;
    w_alert_nx = r_alert_val;
    w_ms_nx    = r_strobe ? r_ms + MW'(1) : r_ms;
    if (io_bus.alertReq) begin
      w_state_nx = ST_ALERT;
      w_alert_nx = io_bus.alertVal;
      w_ms_nx    = '0;
    end else if ((r_state == ST_ALERT) && !w_alert_exp) begin
      w_state_nx = ST_ALERT;
    end else if (io_bus.selForce[2]) begin
      w_state_nx = ST_FORCE;
      w_cur_nx   = io_bus.selForce[1:0];
      w_ms_nx    = '0;
    end else if (|io_bus.srcValid) begin
      w_state_nx = ST_ROTATE;
      if (r_state == ST_ROTATE) begin
        // A dropped current source advances at once, not at dwell expiry.
        if (!io_bus.srcValid[r_cur] || w_dwell_exp) begin
          w_cur_nx = w_pick_adv;
          w_ms_nx  = '0;
        end else begin
          w_cur_nx = r_cur;
        end
      end else begin
        // Entering rotation (idle, force release or alert end) keeps r_cur if valid.
        w_cur_nx = w_pick_inc;
      end
    end else begin
      w_state_nx = ST_IDLE;
      w_ms_nx    = '0;
    end
    if ((w_state_nx != r_state) || (w_cur_nx != r_cur)) begin
      w_ms_nx = '0;
    end else begin
      w_ms_nx = w_ms_nx;
    end
  end

  // State register and registered driver outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cur       <= 2'd0;
      r_ms        <= '0;
      r_alert_val <= 32'd0;
      r_disp      <= 32'd0;
      r_cur_out   <= 3'd7;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cur       <= w_cur_nx;
      r_ms        <= w_ms_nx;
      r_alert_val <= w_alert_nx;
      r_busy      <= (w_state_nx == ST_ALERT);
      case (w_state_nx)
        ST_ROTATE, ST_FORCE: begin
          r_disp    <= w_sel_val;
          r_cur_out <= {1'b0, w_cur_nx};
        end
        ST_ALERT: begin
          r_disp    <= w_alert_nx;
          r_cur_out <= 3'd4;
        end
        default: begin
          r_disp    <= 32'd0;
          r_cur_out <= 3'd7;
        end
      endcase
    end
  end

  assign io_bus.outDispVal     = r_disp;
  assign io_bus.outStrobe1kHz  = r_strobe;
  assign io_bus.outStrobeNoise = r_noise;
  assign io_bus.outCurSrc      = r_cur_out;
  assign io_bus.outAlertBusy   = r_busy;

endmodule

// File: tb/tb_seg7_disp_sched.sv
// Directed bench for seg7_disp_sched with CLK_KHZ=4, DWELL_MS=3, ALERT_MS=2.
// cyc counts clock edges since reset release; all checks happen 1 time unit
// after the edge named by cyc, inputs change at the same point.
module tb_seg7_disp_sched;
  logic clock;
  logic reset;
  seg7_disp_sched_if bus ();

  seg7_disp_sched #(.CLK_KHZ(4), .DWELL_MS(3), .ALERT_MS(2)) dut (
    .clock  (clock),
    .reset  (reset),
    .io_bus (bus)
  );

  int          n_vec;
  int          n_fail;
  int          cyc;
  int          toggles;
  logic [15:0] m_lfsr;
  logic        m_noise;
  logic        prev_noise;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock edge; tracks the reference noise sequence.
  task automatic tick();
    logic rs;
    rs = reset;
    @(posedge clock);
    #1;
    if (rs) begin
      cyc     = 0;
      m_lfsr  = 16'hACE1;
      m_noise = 1'b0;
    end else begin
      cyc++;
      m_noise = m_lfsr[0];
      m_lfsr  = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s at cyc %0d: got %h expected %h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] disp, input logic [2:0] cur, input logic busy);
    chk({tag, ".disp"}, bus.outDispVal, disp);
    chk({tag, ".cur"}, {29'd0, bus.outCurSrc}, {29'd0, cur});
    chk({tag, ".busy"}, {31'd0, bus.outAlertBusy}, {31'd0, busy});
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    cyc = 0;
    toggles = 0;
    m_lfsr = 16'hACE1;
    m_noise = 1'b0;
    reset = 1'b1;
    bus.srcVal = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    bus.srcValid = 4'b0000;
    bus.selForce = 3'b000;
    bus.alertReq = 1'b0;
    bus.alertVal = 32'd0;
    tick();
    tick();
    chk_out("rst", 32'd0, 3'd7, 1'b0);
    chk("rst.strobe", {31'd0, bus.outStrobe1kHz}, 32'd0);
    chk("rst.noise", {31'd0, bus.outStrobeNoise}, 32'd0);
    reset = 1'b0;

    // 1: idle, strobe every 4 clocks from edge 4, noise follows the LFSR.
    prev_noise = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t1.strobe", {31'd0, bus.outStrobe1kHz}, {31'd0, (k % 4 == 0)});
      chk("t1.noise", {31'd0, bus.outStrobeNoise}, {31'd0, m_noise});
      if (bus.outStrobeNoise !== prev_noise) toggles++;
      prev_noise = bus.outStrobeNoise;
    end
    chk("t1.noise_moves", {31'd0, (toggles > 2)}, 32'd1);
    chk_out("t1.idle", 32'd0, 3'd7, 1'b0);

    // 2: rotation over sources 0,1,3, each held 12 clocks.
    bus.srcValid = 4'b1011;
    run_to(9);   chk_out("t2.s0a", 32'h1111_1111, 3'd0, 1'b0);
    run_to(20);  chk_out("t2.s0b", 32'h1111_1111, 3'd0, 1'b0);
    run_to(21);  chk_out("t2.s1a", 32'h2222_2222, 3'd1, 1'b0);
    run_to(32);  chk_out("t2.s1b", 32'h2222_2222, 3'd1, 1'b0);
    run_to(33);  chk_out("t2.s3a", 32'h4444_4444, 3'd3, 1'b0);
    run_to(44);  chk_out("t2.s3b", 32'h4444_4444, 3'd3, 1'b0);
    run_to(45);  chk_out("t2.wrap", 32'h1111_1111, 3'd0, 1'b0);

    // 3: drop source 1 mid-dwell, then drop all.
    run_to(57);  chk_out("t3.s1", 32'h2222_2222, 3'd1, 1'b0);
    run_to(62);
    bus.srcValid = 4'b1001;
    run_to(63);  chk_out("t3.adv", 32'h4444_4444, 3'd3, 1'b0);
    run_to(72);  chk_out("t3.hold", 32'h4444_4444, 3'd3, 1'b0);
    run_to(73);  chk_out("t3.next", 32'h1111_1111, 3'd0, 1'b0);
    bus.srcValid = 4'b0000;
    run_to(74);  chk_out("t3.idle", 32'd0, 3'd7, 1'b0);

    // 4: force an invalid source, live value, release to next valid.
    bus.srcValid = 4'b1011;
    bus.selForce = 3'b110;
    run_to(75);  chk_out("t4.f2a", 32'h3333_3333, 3'd2, 1'b0);
    run_to(90);  chk_out("t4.f2b", 32'h3333_3333, 3'd2, 1'b0);
    bus.srcVal[95:64] = 32'h3333_AAAA;
    run_to(91);  chk_out("t4.live", 32'h3333_AAAA, 3'd2, 1'b0);
    run_to(100); chk_out("t4.f2c", 32'h3333_AAAA, 3'd2, 1'b0);
    bus.selForce = 3'b000;
    run_to(101); chk_out("t4.rel", 32'h4444_4444, 3'd3, 1'b0);

    // 5: alert, re-alert restarts timer, resume saved source with fresh dwell.
    run_to(102);
    bus.alertReq = 1'b1;
    bus.alertVal = 32'hDEAD_BEEF;
    run_to(103);
    bus.alertReq = 1'b0;
    chk_out("t5.a1", 32'hDEAD_BEEF, 3'd4, 1'b1);
    run_to(106); chk_out("t5.a1b", 32'hDEAD_BEEF, 3'd4, 1'b1);
    bus.alertReq = 1'b1;
    bus.alertVal = 32'hCAFE_0001;
    run_to(107);
    bus.alertReq = 1'b0;
    chk_out("t5.a2", 32'hCAFE_0001, 3'd4, 1'b1);
    run_to(112); chk_out("t5.a2b", 32'hCAFE_0001, 3'd4, 1'b1);
    run_to(113); chk_out("t5.resume", 32'h4444_4444, 3'd3, 1'b0);
    run_to(124); chk_out("t5.dwell", 32'h4444_4444, 3'd3, 1'b0);
    run_to(125); chk_out("t5.next", 32'h1111_1111, 3'd0, 1'b0);

    // 6: reset during alert, with an alert request in the reset cycle.
    bus.alertReq = 1'b1;
    bus.alertVal = 32'h1234_5678;
    run_to(126);
    bus.alertReq = 1'b0;
    chk_out("t6.alert", 32'h1234_5678, 3'd4, 1'b1);
    run_to(127);
    reset = 1'b1;
    bus.alertReq = 1'b1;
    tick();
    chk_out("t6.rst", 32'd0, 3'd7, 1'b0);
    chk("t6.rst.strobe", {31'd0, bus.outStrobe1kHz}, 32'd0);
    chk("t6.rst.noise", {31'd0, bus.outStrobeNoise}, 32'd0);
    reset = 1'b0;
    bus.alertReq = 1'b0;
    tick();
    chk_out("t6.after", 32'h1111_1111, 3'd0, 1'b0);
    chk("t6.noise1", {31'd0, bus.outStrobeNoise}, 32'd1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("t6.strobe", {31'd0, bus.outStrobe1kHz}, {31'd0, (k % 4 == 0)});
      chk("t6.noise", {31'd0, bus.outStrobeNoise}, {31'd0, m_noise});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
